// File: rtl/exec_arith_mc_pkg.sv
// Shared definitions for the multi-cycle arithmetic execute stage:
// opcode map, flag bit positions and divider FSM state encodings.
package exec_arith_mc_pkg;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_CMP = 5'd4;
    localparam logic [4:0] OP_ABS = 5'd5;
    localparam logic [4:0] OP_ADC = 5'd6;
    localparam logic [4:0] OP_SBC = 5'd7;

    localparam int unsigned F_C = 3;
    localparam int unsigned F_Z = 2;
    localparam int unsigned F_S = 1;
    localparam int unsigned F_V = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic sets_flags(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) ||
               (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/exec_arith_mc_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle (IDLE/BUSY/DONE).
// Define EXEC_DIV_SIGNED_EN for signed division (truncating toward zero).
module exec_div_iter
    import exec_arith_mc_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         ack,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

`ifdef EXEC_DIV_SIGNED_EN
    localparam bit SIGNED = 1'b1;
`else
    localparam bit SIGNED = 1'b0;
`endif
    localparam int unsigned CW = $clog2(W);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [W-1:0]  rem;
    logic [W-1:0]  q;
    logic [W-1:0]  d;
    logic          neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          ge;

    // Signed mode divides magnitudes; a zero divisor yields an all-ones
    // magnitude, which the sign fix-up turns into 1 for negative dividends.
    assign a_mag = (SIGNED && dividend[W-1]) ? -dividend : dividend;
    assign b_mag = (SIGNED && divisor[W-1])  ? -divisor  : divisor;

    assign shifted = {rem, q[W-1]};
    assign diff    = shifted - {1'b0, d};
    assign ge      = ~diff[W];

    assign busy     = (state == S_BUSY);
    assign done     = (state == S_DONE);
    assign quotient = neg ? -q : q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            count <= '0;
            rem   <= '0;
            q     <= '0;
            d     <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    q     <= a_mag;
                    d     <= b_mag;
                    rem   <= '0;
                    neg   <= SIGNED & (dividend[W-1] ^ divisor[W-1]);
                    count <= CW'(W - 1);
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    rem <= ge ? diff[W-1:0] : shifted[W-1:0];
                    q   <= {q[W-2:0], ge};
                    if (count == '0) state <= S_DONE;
                    else             count <= count - CW'(1);
                end
                S_DONE: if (ack) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/exec_arith_mc.sv
// Multi-cycle arithmetic execute stage with flags register and iterative divider.
// Define EXEC_DIV_SIGNED_EN to make DIV signed.
module exec_arith_mc
    import exec_arith_mc_pkg::*;
#(
    parameter int unsigned W_OPR = 16,
    parameter int unsigned W_RD  = 4,
    parameter int unsigned W_OPC = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic             stall_i,
    output logic             stall_o,
    input  logic [W_OPC-1:0] opecode_i,
    input  logic [W_OPR-1:0] opr0_i,
    input  logic [W_OPR-1:0] opr1_i,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  wb_r_i,
    output logic             v_o,
    output logic [W_OPR-1:0] result_o,
    output logic [W_RD-1:0]  wb_r_o,
    output logic             wb_o,
    output logic [3:0]       flags_o
);

    logic [4:0]       op;
    logic             unused_opc;
    logic             is_div;
    logic             is_sub;
    logic             cin;
    logic [W_OPR-1:0] b_eff;
    logic [W_OPR:0]   sum;
    logic [W_OPR-1:0] prod;
    logic [W_OPR-1:0] abs_a;
    logic [W_OPR-1:0] res;
    logic [3:0]       new_flags;
    logic             div_busy;
    logic             div_done;
    logic [W_OPR-1:0] quotient;

    assign op         = opecode_i[4:0];
    assign unused_opc = ^opecode_i[W_OPC-1:5];
    assign is_div     = (op == OP_DIV);
    assign is_sub     = (op == OP_SUB) || (op == OP_CMP) || (op == OP_SBC);

    // One shared adder: subtraction is A + ~B + cin, so C=1 means no borrow.
    always_comb begin
        cin = 1'b0;
        if ((op == OP_SUB) || (op == OP_CMP))      cin = 1'b1;
        else if ((op == OP_ADC) || (op == OP_SBC)) cin = flags_o[F_C];
    end

    assign b_eff = is_sub ? ~opr1_i : opr1_i;
    assign sum   = {1'b0, opr0_i} + {1'b0, b_eff} + {{W_OPR{1'b0}}, cin};
    assign prod  = opr0_i * opr1_i;
    assign abs_a = opr0_i[W_OPR-1] ? -opr0_i : opr0_i;

    always_comb begin
        res = '0;
        case (op)
            OP_ADD, OP_SUB, OP_CMP, OP_ADC, OP_SBC: res = sum[W_OPR-1:0];
            OP_MUL:  res = prod;
            OP_ABS:  res = abs_a;
            default: res = '0;
        endcase
    end

    always_comb begin
        new_flags      = '0;
        new_flags[F_C] = sum[W_OPR];
        new_flags[F_Z] = (sum[W_OPR-1:0] == '0);
        new_flags[F_S] = sum[W_OPR-1];
        new_flags[F_V] = (opr0_i[W_OPR-1] == b_eff[W_OPR-1]) &&
                         (sum[W_OPR-1] != opr0_i[W_OPR-1]);
    end

    exec_div_iter #(.W(W_OPR)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (v_i & is_div & ~stall_i),
        .ack      (~stall_i),
        .dividend (opr0_i),
        .divisor  (opr1_i),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    assign stall_o = stall_i | div_busy | (~div_busy & ~div_done & v_i & is_div);

    // In DONE the DIV still held on the inputs is the completing instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_o      <= 1'b0;
            result_o <= '0;
            wb_r_o   <= '0;
            wb_o     <= 1'b0;
            flags_o  <= '0;
        end else if (!stall_i) begin
            if (div_done) begin
                v_o      <= 1'b1;
                result_o <= quotient;
                wb_r_o   <= wb_r_i;
                wb_o     <= wb_i;
            end else if (stall_o) begin
                v_o  <= 1'b0;
                wb_o <= 1'b0;
            end else begin
                v_o      <= v_i;
                result_o <= res;
                wb_r_o   <= wb_r_i;
                wb_o     <= wb_i & v_i & (op != OP_CMP);
                if (v_i && sets_flags(op)) flags_o <= new_flags;
            end
        end
    end

endmodule

// File: tb/tb_exec_arith_mc.sv
// Directed, table-driven bench for exec_arith_mc (W_OPR=16) plus divider sequences.
module tb_exec_arith_mc;

    logic        clk;
    logic        reset;
    logic        v_i;
    logic        stall_i;
    logic        stall_o;
    logic [6:0]  opecode_i;
    logic [15:0] opr0_i;
    logic [15:0] opr1_i;
    logic        wb_i;
    logic [3:0]  wb_r_i;
    logic        v_o;
    logic [15:0] result_o;
    logic [3:0]  wb_r_o;
    logic        wb_o;
    logic [3:0]  flags_o;

    int tests;
    int fails;

    exec_arith_mc #(.W_OPR(16), .W_RD(4), .W_OPC(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .v_i       (v_i),
        .stall_i   (stall_i),
        .stall_o   (stall_o),
        .opecode_i (opecode_i),
        .opr0_i    (opr0_i),
        .opr1_i    (opr1_i),
        .wb_i      (wb_i),
        .wb_r_i    (wb_r_i),
        .v_o       (v_o),
        .result_o  (result_o),
        .wb_r_o    (wb_r_o),
        .wb_o      (wb_o),
        .flags_o   (flags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        wb;
        logic [3:0]  rd;
        logic [15:0] res;
        logic        exp_wb;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_div(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp, input int hold);
        int cnt;
        int bub_bad;
        int hold_bad;
        cnt      = 0;
        bub_bad  = 0;
        hold_bad = 0;
        @(negedge clk);
        opecode_i = 7'd3; opr0_i = a; opr1_i = b;
        v_i = 1'b1; wb_i = 1'b1; wb_r_i = 4'd7; stall_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!stall_o) break;
            cnt++;
            @(posedge clk); #1;
            if (v_o !== 1'b0) bub_bad++;
            @(negedge clk);
        end
        check({name, " stall cycles"}, 32'(cnt), 32'd17);
        check({name, " bubbles"}, 32'(bub_bad), 32'd0);
        if (hold > 0) begin
            stall_i = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (v_o !== 1'b0) hold_bad++;
            end
            check({name, " held in DONE"}, 32'(hold_bad), 32'd0);
            @(negedge clk);
            stall_i = 1'b0;
        end
        @(posedge clk); #1;
        check({name, " v_o"}, 32'(v_o), 32'd1);
        check({name, " quotient"}, 32'(result_o), 32'(exp));
        check({name, " wb_o"}, 32'(wb_o), 32'd1);
        check({name, " wb_r_o"}, 32'(wb_r_o), 32'd7);
        @(negedge clk);
        v_i = 1'b0;
        #1;
        check({name, " no restart"}, 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        check({name, " produced once"}, 32'(v_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        tests = 0;
        fails = 0;
        //            op     a         b         wb    rd     res       ewb   flags
        vecs[0]  = '{7'd0,  16'hFFFF, 16'h0001, 1'b1, 4'd3,  16'h0000, 1'b1, 4'hC};
        vecs[1]  = '{7'd1,  16'h8000, 16'h0001, 1'b1, 4'd4,  16'h7FFF, 1'b1, 4'h9};
        vecs[2]  = '{7'd4,  16'h0005, 16'h0005, 1'b1, 4'd5,  16'h0000, 1'b0, 4'hC};
        vecs[3]  = '{7'd0,  16'hFFFF, 16'h0002, 1'b1, 4'd6,  16'h0001, 1'b1, 4'h8};
        vecs[4]  = '{7'd6,  16'h0001, 16'h0001, 1'b1, 4'd7,  16'h0003, 1'b1, 4'h0};
        vecs[5]  = '{7'd4,  16'h0001, 16'h0002, 1'b1, 4'd8,  16'hFFFF, 1'b0, 4'h2};
        vecs[6]  = '{7'd7,  16'h0005, 16'h0003, 1'b1, 4'd9,  16'h0001, 1'b1, 4'h8};
        vecs[7]  = '{7'd2,  16'h0100, 16'h0100, 1'b1, 4'd10, 16'h0000, 1'b1, 4'h8};
        vecs[8]  = '{7'd2,  16'h0003, 16'h0005, 1'b0, 4'd11, 16'h000F, 1'b0, 4'h8};
        vecs[9]  = '{7'd5,  16'hFFFB, 16'h0000, 1'b1, 4'd12, 16'h0005, 1'b1, 4'h8};
        vecs[10] = '{7'd5,  16'h8000, 16'h0000, 1'b1, 4'd13, 16'h8000, 1'b1, 4'h8};
        vecs[11] = '{7'd8,  16'h1234, 16'h0001, 1'b1, 4'd14, 16'h0000, 1'b1, 4'h8};
        vecs[12] = '{7'h60, 16'h7FFF, 16'h0001, 1'b1, 4'd15, 16'h8000, 1'b1, 4'h3};
        vecs[13] = '{7'd7,  16'h0000, 16'h0000, 1'b1, 4'd1,  16'hFFFF, 1'b1, 4'h2};
        vecs[14] = '{7'd6,  16'hFFFF, 16'h0000, 1'b1, 4'd2,  16'hFFFF, 1'b1, 4'h2};
        vecs[15] = '{7'd1,  16'h0003, 16'h0005, 1'b1, 4'd3,  16'hFFFE, 1'b1, 4'h2};
        vecs[16] = '{7'd0,  16'h0001, 16'hFFFF, 1'b1, 4'd4,  16'h0000, 1'b1, 4'hC};
        vecs[17] = '{7'd7,  16'h0005, 16'h0003, 1'b1, 4'd5,  16'h0002, 1'b1, 4'h8};

        reset = 1'b0; v_i = 1'b0; stall_i = 1'b0; opecode_i = '0;
        opr0_i = '0; opr1_i = '0; wb_i = 1'b0; wb_r_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset v_o", 32'(v_o), 32'd0);
        check("reset result_o", 32'(result_o), 32'd0);
        check("reset wb_o", 32'(wb_o), 32'd0);
        check("reset flags_o", 32'(flags_o), 32'd0);
        check("reset stall_o", 32'(stall_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            opecode_i = vecs[i].op; opr0_i = vecs[i].a; opr1_i = vecs[i].b;
            wb_i = vecs[i].wb; wb_r_i = vecs[i].rd; v_i = 1'b1; stall_i = 1'b0;
            @(posedge clk); #1;
            check($sformatf("vec%0d v_o", i), 32'(v_o), 32'd1);
            check($sformatf("vec%0d result", i), 32'(result_o), 32'(vecs[i].res));
            check($sformatf("vec%0d wb_o", i), 32'(wb_o), 32'(vecs[i].exp_wb));
            check($sformatf("vec%0d wb_r_o", i), 32'(wb_r_o), 32'(vecs[i].rd));
            check($sformatf("vec%0d flags", i), 32'(flags_o), 32'(vecs[i].fl));
        end

        run_div("div 100/7", 16'd100, 16'd7, 16'd14, 0);
        check("div keeps flags", 32'(flags_o), 32'h8);
        run_div("div 9/0", 16'd9, 16'd0, 16'hFFFF, 0);
        run_div("div 100/7 held", 16'd100, 16'd7, 16'd14, 3);
`ifdef EXEC_DIV_SIGNED_EN
        run_div("div -100/7", 16'hFF9C, 16'd7, 16'hFFF2, 0);
        run_div("div min/-1", 16'h8000, 16'hFFFF, 16'h8000, 0);
        run_div("div -10/0", 16'hFFF6, 16'd0, 16'h0001, 0);
`else
        run_div("div FF9C/7", 16'hFF9C, 16'd7, 16'h2484, 0);
        run_div("div 8000/FFFF", 16'h8000, 16'hFFFF, 16'h0000, 0);
        run_div("div FFF6/0", 16'hFFF6, 16'd0, 16'hFFFF, 0);
`endif

        // Abort a division with reset during its 5th BUSY cycle.
        @(negedge clk);
        opecode_i = 7'd3; opr0_i = 16'd100; opr1_i = 16'd7;
        v_i = 1'b1; wb_i = 1'b1; wb_r_i = 4'd9; stall_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; v_i = 1'b0;
        #1;
        check("abort v_o", 32'(v_o), 32'd0);
        check("abort result_o", 32'(result_o), 32'd0);
        check("abort wb_r_o", 32'(wb_r_o), 32'd0);
        check("abort wb_o", 32'(wb_o), 32'd0);
        check("abort flags_o", 32'(flags_o), 32'd0);
        check("abort stall_o", 32'(stall_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        opecode_i = 7'd0; opr0_i = 16'd2; opr1_i = 16'd3;
        v_i = 1'b1; wb_i = 1'b1; wb_r_i = 4'd2;
        #1;
        check("post-abort stall_o", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        check("post-abort add v_o", 32'(v_o), 32'd1);
        check("post-abort add result", 32'(result_o), 32'd5);
        @(negedge clk);
        v_i = 1'b0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (v_o !== 1'b0) stray++;
        end
        check("no result after abort", 32'(stray), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exec_arith_mc.md
Name: exec_arith_mc

Overview:
- Parametrised, multi-cycle arithmetic execute stage for the venus pipeline, one generation beyond the single-cycle execute stage.
- Inputs come from the decode/register-read stage. Outputs feed the writeback/ldst stage through one output register.
- Adds a flags register updated by arithmetic ops, ADC/SBC support, an iterative divider with upstream stall, and writeback gating taken from wb_i.

Parameters:
W_OPR, 16, operand/result width (>=4)
W_RD, 4, writeback register index width
W_OPC, 7, opcode width; only opcode_i[4:0] is decoded

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
v_i  in  1  input instruction valid
stall_i  in  1  downstream stall
stall_o  out  1  stall to upstream
opecode_i  in  W_OPC  opcode
opr0_i  in  W_OPR  operand A
opr1_i  in  W_OPR  operand B
wb_i  in  1  instruction writes back
wb_r_i  in  W_RD  destination register
v_o  out  1  output valid
result_o  out  W_OPR  registered result
wb_r_o  out  W_RD  registered destination
wb_o  out  1  write enable (registered wb & v_o)
flags_o  out  4  {C,Z,S,V} flags register

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset.
- Reset values: v_o=0, result_o=0, wb_r_o=0, wb_o=0, flags_o=0, state=IDLE, divider counter=0.
- Opcode map (opecode_i[4:0]): ADD=0, SUB=1, MUL=2, DIV=3, CMP=4, ABS=5, ADC=6, SBC=7. Any other code gives result 0 and leaves flags unchanged.
- Arithmetic (all results modulo 2^W_OPR):
  - ADD: A+B. SUB and CMP: A-B. ADC: A+B+C. SBC: A-B-(1-C), where C is the carry flag.
  - MUL: low W_OPR bits of the unsigned product.
  - ABS: two's-complement magnitude of A; ABS of the most-negative value returns the same value.
- Flags are updated by ADD, SUB, CMP, ADC and SBC only:
  - C = carry out of the W_OPR-bit adder; for subtraction C=1 means no borrow.
  - Z = result==0. S = result MSB. V = signed overflow.
- CMP updates flags and registers its result, but forces wb_o=0.
- Capture: an instruction is captured when the output register loads with v_i=1. Captured ops update the output register and flags. Single-cycle ops have 1-cycle latency.
- Pipeline advance: when stall_i=0 and stall_o=0, the output register loads {v_i, result, wb_r_i, wb_i}.
- Stall: stall_o = stall_i | (state==BUSY) | (state==IDLE & v_i & op==DIV).
- Bubbles: while stall_o=1 because of the divider and stall_i=0, the output register loads v=0.
- Divider FSM (unsigned restoring, 1 quotient bit per cycle):
  - IDLE: v_i & DIV & ~stall_i -> latch A and B, count=W_OPR-1, go to BUSY.
  - BUSY: one iteration per cycle regardless of stall_i. At count==0 go to DONE, otherwise decrement.
  - DONE: stall_o=stall_i. The held DIV on the inputs is treated as completion, not a restart. When stall_i=0, the output register loads the quotient with v_o=1 and the FSM goes to IDLE.
  - If stall_i=1 in DONE, the quotient is held.
  - Operands and v_i are ignored while BUSY.
- Division by zero: quotient = all ones; no exception.
- DIV timing: stall_o is high for W_OPR+1 cycles starting at presentation. The result appears on v_o W_OPR+2 cycles after first presentation when stall_i=0.
- Reset mid-division aborts the division: state returns to IDLE and no result is produced.

Optional Feature:
- Macro: EXEC_DIV_SIGNED_EN.
- When defined, DIV is signed:
  - operands are converted to magnitudes, the quotient is negated when the signs differ, and the quotient truncates toward zero;
  - most-negative / -1 returns the most-negative value;
  - divide by zero returns all ones when A>=0 and 1 when A<0.
- When undefined, DIV is unsigned as above. Latency is identical in both modes.

Decomposition:
- Shared package/include holds:
  - opcode localparams (OP_ADD..OP_SBC);
  - flag bit indices (F_C=3, F_Z=2, F_S=1, F_V=0);
  - FSM state encodings (S_IDLE, S_BUSY, S_DONE).
- One sub-module, exec_div_iter: start/operands in, busy/done/quotient out, containing the counter, partial remainder and quotient shift register, plus the optional signed wrapper.

Test Plan (W_OPR=16):
- ADD 0xFFFF+0x0001 with wb_i=1 -> next cycle result_o=0x0000, wb_o=1, flags_o=C1 Z1 S0 V0.
- SUB 0x8000-0x0001 -> result 0x7FFF, V=1, C=1. A following CMP 5,5 -> Z=1, wb_o=0, and the previous result is not written.
- ADD 0xFFFF+0x0002 sets C=1; then ADC 1+1 -> result 0x0003. Then SBC 5-3 after a CMP that left C=0 -> result 0x0001.
- DIV 100/7 with stall_i=0 -> stall_o high 17 cycles, v_o=0 bubbles during them, then result_o=14 with v_o=1. DIV 9/0 -> 0xFFFF.
- DIV 100/7 with stall_i=1 held for 3 cycles in DONE -> quotient delayed by 3 cycles and produced exactly once, with no restart.
- Assert reset at the 5th BUSY cycle -> all outputs are 0 and state is IDLE. Next ADD 2+3 -> 5 in 1 cycle.
- With EXEC_DIV_SIGNED_EN: DIV 0xFF9C(-100)/7 -> 0xFFF2(-14); DIV 0x8000/0xFFFF -> 0x8000.
